slice_pack_wb: RTL

- Write-back packer for the slice-serial Keccak-f[1600] datapath of the hash core; it is the writer-side counterpart of the theta pre-fetch stage.
- Accepts one 25-bit slice per cycle from the round datapath. Lane l of the slice is bit l.
- Gathers 8 consecutive slices into one 200-bit state-RAM word and issues each completed word to the RAM write port.
- Uses a two-bank double buffer so slice intake overlaps the RAM write.

---
 rtl/slice_pack_wb.sv | 131 +++++++++++++
 1 files changed

// File: rtl/slice_pack_wb.sv
// Write-back packer: gathers 8 slice-serial Keccak slices per 200-bit state-RAM
// word and writes completed words through a two-bank double buffer.

module slice_pack_lane #(
   parameter int SPW = 8,
   parameter int SW  = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           we,
   input  logic           fp,
   input  logic           rp,
   input  logic [SW-1:0]  s,
   input  logic           d,
   output logic [0:SPW-1] q
);
   logic [1:0][0:SPW-1] bank;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  bank        <= '0;
      else if (we) bank[fp][s] <= d;
   end

   assign q = bank[rp];
endmodule

module slice_pack_wb #(
   parameter int SPW    = 8,
   parameter int NWORDS = 8,
   parameter int AW     = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              slice_vld,
   input  logic [0:24]       slice_in,
   output logic              slice_rdy,
   output logic              wr_req,
   input  logic              wr_gnt,
   output logic [AW-1:0]     wr_addr,
   output logic [0:25*SPW-1] wr_data,
   output logic              round_done,
   output logic              busy
);
   localparam int NL = 25;
   localparam int SW = $clog2(SPW);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t               state_q, state_d;
   logic [SW-1:0]        s_q;
   logic [AW-1:0]        w_q;
   logic                 fp_q, rp_q;
   logic [1:0]           full_q;
   logic [1:0][AW-1:0]   addr_q;
   logic                 round_done_q;
   logic                 acc, gnt, word_end, last_word, final_gnt;

   assign slice_rdy  = (state_q == RUN) && !full_q[fp_q];
   assign acc        = slice_vld && slice_rdy;
   assign wr_req     = full_q[rp_q];
   assign wr_addr    = addr_q[rp_q];
   assign gnt        = wr_req && wr_gnt;
   assign word_end   = (s_q == SW'(SPW-1));
   assign last_word  = (w_q == AW'(NWORDS-1));
   // Only the top-address word can be the last one granted in a round.
   assign final_gnt  = (state_q == DRAIN) && gnt && (addr_q[rp_q] == AW'(NWORDS-1));
   assign round_done = round_done_q;
   assign busy       = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (acc && word_end && last_word) state_d = DRAIN;
         DRAIN:   if (final_gnt) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         s_q          <= '0;
         w_q          <= '0;
         fp_q         <= 1'b0;
         rp_q         <= 1'b0;
         full_q       <= '0;
         addr_q       <= '0;
         round_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         round_done_q <= final_gnt;
         if (state_q == IDLE && start) begin
            s_q  <= '0;
            w_q  <= '0;
            fp_q <= 1'b0;
            rp_q <= 1'b0;
         end
         if (acc) begin
            if (word_end) begin
               s_q          <= '0;
               full_q[fp_q] <= 1'b1;
               addr_q[fp_q] <= w_q;
               w_q          <= last_word ? '0 : w_q + 1'b1;
               fp_q         <= ~fp_q;
            end else begin
               s_q <= s_q + 1'b1;
            end
         end
         // Accept needs !full[fp] and grant needs full[rp], so they never hit the same bank.
         if (gnt) begin
            full_q[rp_q] <= 1'b0;
            rp_q         <= ~rp_q;
         end
      end
   end

   for (genvar l = 0; l < NL; l++) begin : g_lane
      slice_pack_lane #(.SPW(SPW), .SW(SW)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (acc),
         .fp    (fp_q),
         .rp    (rp_q),
         .s     (s_q),
         .d     (slice_in[l]),
         .q     (wr_data[SPW*l +: SPW])
      );
   end
endmodule
